// File: rtl/rom_word_fetch_if.sv
// Request/ROM/response bundle for rom_word_fetch.
// The slave modport is the fetch block's view; master is the requester/ROM side.
interface rom_word_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_illegal;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_error;
    logic              rsp_misaligned;

    modport slave (
        input  req_valid, req_addr, rom_data, rom_illegal, rsp_ready,
        output req_ready, rom_addr, rsp_valid, rsp_data, rsp_error, rsp_misaligned
    );

    modport master (
        output req_valid, req_addr, rom_data, rom_illegal, rsp_ready,
        input  req_ready, rom_addr, rsp_valid, rsp_data, rsp_error, rsp_misaligned
    );
endinterface

// File: rtl/rom_word_fetch.sv
// Byte-wide ROM to 32-bit little-endian word fetch front-end.
// Optional ALIGN_CHECK_EN: misaligned requests skip the ROM and return an error response.
module rom_word_fetch #(
    parameter int ROM_LATENCY = 0,
    parameter int ADDR_W      = 32
) (
    input  logic             w_clk_low,
    input  logic             rst,
    rom_word_fetch_if.slave  bus
);
    localparam int WW = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic              mis;
    logic [7:0]        byte_v;

    always_comb begin
`ifdef ALIGN_CHECK_EN
        mis = |bus.req_addr[1:0];
`else
        mis = 1'b0;
`endif
    end

    // Illegal bytes are zeroed but never abort the fetch.
    assign byte_v = bus.rom_illegal ? 8'h00 : bus.rom_data;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rom_addr_d  = rom_addr_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        word_d      = word_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        rsp_mis_d   = rsp_mis_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    base_d      = bus.req_addr;
                    err_d       = 1'b0;
                    if (mis) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'h0;
                        rsp_error_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        rom_addr_d = bus.req_addr;
                        idx_d      = 2'd0;
                        wait_d     = '0;
                    end
                end
            end
            FETCH: begin
                if (wait_q == WW'(ROM_LATENCY)) begin
                    word_d[idx_q*8 +: 8] = byte_v;
                    err_d = err_q | bus.rom_illegal;
                    if (idx_q != 2'd3) begin
                        rom_addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                        idx_d      = idx_q + 2'd1;
                        wait_d     = '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {byte_v, word_q[23:0]};
                        rsp_error_d = err_q | bus.rom_illegal;
                        rsp_mis_d   = 1'b0;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk_low) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rom_addr_q  <= '0;
            idx_q       <= 2'd0;
            wait_q      <= '0;
            word_q      <= 32'h0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_error_q <= 1'b0;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rom_addr_q  <= rom_addr_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            word_q      <= word_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rom_addr       = rom_addr_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_error      = rsp_error_q;
    assign bus.rsp_misaligned = rsp_mis_q;
endmodule

// File: tb/tb_rom_word_fetch.sv
// Randomized bench for rom_word_fetch against a 256-byte ROM model and a word-level reference.
// Honors ALIGN_CHECK_EN the same way the design does.
module tb_rom_word_fetch;
    localparam int ROM_LAT = 0;
    localparam int ROM_SZ  = 256;

    logic w_clk_low = 1'b0;
    logic rst       = 1'b1;
    always #5 w_clk_low = ~w_clk_low;

    rom_word_fetch_if #(.ADDR_W(32)) bus ();

    rom_word_fetch #(.ROM_LATENCY(ROM_LAT), .ADDR_W(32)) u_dut (
        .w_clk_low (w_clk_low),
        .rst       (rst),
        .bus       (bus)
    );

    logic [7:0] rom_mem [ROM_SZ];

    // Out-of-range reads return junk so that byte zeroing is observable.
    generate
        if (ROM_LAT == 0) begin : g_comb_rom
            always_comb begin
                bus.rom_illegal = (bus.rom_addr >= 32'(ROM_SZ));
                bus.rom_data    = bus.rom_illegal ? 8'hA5 : rom_mem[bus.rom_addr[7:0]];
            end
        end else begin : g_reg_rom
            always_ff @(posedge w_clk_low) begin
                bus.rom_illegal <= (bus.rom_addr >= 32'(ROM_SZ));
                bus.rom_data    <= (bus.rom_addr >= 32'(ROM_SZ)) ? 8'hA5 : rom_mem[bus.rom_addr[7:0]];
            end
        end
    endgenerate

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_rom_addr = 32'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level reference: four wrapped byte addresses, little-endian, illegal -> 0.
    task automatic model(input logic [31:0] a, output logic [31:0] d, output logic e, output logic m);
        logic [31:0] ba;
        d = 32'h0;
        e = 1'b0;
        m = 1'b0;
`ifdef ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            e = 1'b1;
            m = 1'b1;
            return;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            ba = a + 32'(i);
            if (ba < 32'(ROM_SZ)) d = d | (32'(rom_mem[ba[7:0]]) << (8 * i));
            else e = 1'b1;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int hold);
        logic [31:0] ed;
        logic        ee, em, stable;
        logic [31:0] snap;
        int          n;
        model(a, ed, ee, em);
        @(negedge w_clk_low);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b0;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge w_clk_low);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(posedge w_clk_low);
            #1;
            n++;
        end
        chk("latency", 64'(n + 1), em ? 64'd1 : 64'(4 * (1 + ROM_LAT) + 1));
        chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
        chk("rsp_error", 64'(bus.rsp_error), 64'(ee));
        chk("rsp_misaligned", 64'(bus.rsp_misaligned), 64'(em));
        if (!em) exp_rom_addr = a + 32'd3;
        chk("rom_addr", 64'(bus.rom_addr), 64'(exp_rom_addr));
        snap   = bus.rsp_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = $urandom;
            @(posedge w_clk_low);
            #1;
            if (!bus.rsp_valid || bus.rsp_data !== snap || bus.req_ready) stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge w_clk_low);
        #1 bus.rsp_ready = 1'b0;
        chk("post_handshake", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
        chk("data_kept", 64'(bus.rsp_data), 64'(ed));
    endtask

    initial begin
        logic [31:0] a;
        bit          quiet;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < ROM_SZ; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'h11;
        rom_mem[1] = 8'h22;
        rom_mem[2] = 8'h33;
        rom_mem[3] = 8'h44;

        repeat (2) @(posedge w_clk_low);
        #1 rst = 1'b0;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
        chk("rst_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);

        fetch(32'h0, 0);
        fetch(32'h0, 10);
        fetch(32'd254, 2);
        fetch(32'hFFFF_FFFE, 0);
        fetch(32'd5, 1);
        fetch(32'd4, 0);

        // Reset while the third byte is being fetched: transaction must vanish.
        @(negedge w_clk_low);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'd8;
        @(posedge w_clk_low);
        #1 bus.req_valid = 1'b0;
        repeat (2 * (1 + ROM_LAT)) @(posedge w_clk_low);
        #1 rst = 1'b1;
        @(posedge w_clk_low);
        #1 rst = 1'b0;
        exp_rom_addr = 32'h0;
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_rom_addr", 64'(bus.rom_addr), 64'd0);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge w_clk_low);
            #1;
            if (bus.rsp_valid) quiet = 1'b0;
        end
        chk("midrst_no_rsp", 64'(quiet), 64'd1);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 260));
                1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2:       a = $urandom;
                default: a = 32'($urandom_range(240, 255));
            endcase
            fetch(a, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
